bus_arbiter: RTL and testbench

Two-master arbiter for the shared data bus in front of the processor read-data mux and the memory-mapped slaves (data RAM, UART A/B/C, switches, LEDs, seven-segment). It lets the CPU data port (master 0) and a UART-to-RAM loader/DMA (master 1) share the bus.
- Grants one single-word transfer per cycle.
- Rotates priority round-robin and honours a bounded lock for bursts.
- Registers read data back to the granted master and flags accesses to unmapped or misaligned addresses.

---
 rtl/bus_pkg.sv | 53 +++++
 rtl/bus_addr_decode.sv | 22 ++
 rtl/bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the two-master data bus.
//   - state_t      : arbiter FSM states (IDLE, GNT0, GNT1)
//   - dec_t        : address decode result (valid = access may reach a slave,
//                    err = unmapped / misaligned / illegal write)
//   - address map  : data RAM window, switches, LEDs, seven-segment and the
//                    three UARTs with their register offsets
//   - addr_decode  : combinational decode used by the arbiter and the read mux
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   typedef struct packed {
      logic valid;
      logic err;
   } dec_t;

   localparam logic [31:0] RAM_BASE      = 32'h0000_1000;
   localparam logic [31:0] RAM_LAST      = 32'h0000_13F8;
   localparam logic [31:0] SW_ADDR       = 32'h0000_2000;
   localparam logic [31:0] LED_ADDR      = 32'h0000_2004;
   localparam logic [31:0] SEG_ADDR      = 32'h0000_2008;
   localparam logic [31:0] UART_A_BASE   = 32'h0000_2010;
   localparam logic [31:0] UART_B_BASE   = 32'h0000_2020;
   localparam logic [31:0] UART_C_BASE   = 32'h0000_2030;
   localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
   localparam logic [31:0] UART_STAT_OFS = 32'h0000_0008;
   localparam logic [31:0] UART_CTRL_OFS = 32'h0000_000C;

   function automatic logic is_uart_reg(input logic [31:0] addr, input logic [31:0] base);
      return (addr == base + UART_DATA_OFS) ||
             (addr == base + UART_STAT_OFS) ||
             (addr == base + UART_CTRL_OFS);
   endfunction

   function automatic dec_t addr_decode(input logic [31:0] addr, input logic we);
      logic mapped;
      dec_t d;
      mapped = ((addr >= RAM_BASE) && (addr <= RAM_LAST)) ||
               (addr == SW_ADDR) || (addr == LED_ADDR) || (addr == SEG_ADDR) ||
               is_uart_reg(addr, UART_A_BASE) ||
               is_uart_reg(addr, UART_B_BASE) ||
               is_uart_reg(addr, UART_C_BASE);
      // The switch register is input-only, so a write to it is an error.
      d.err   = !mapped || (addr[1:0] != 2'b00) || (we && (addr == SW_ADDR));
      d.valid = !d.err;
      return d;
   endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational address decoder for the data bus.
// Ports:
//   addr_i  in  32  byte address on the bus
//   we_i    in  1   write enable of the access
//   valid_o out 1   access is legal and may strobe a slave
//   err_o   out 1   unmapped, misaligned or write to a read-only register
module bus_addr_decode
   import bus_pkg::*;
(
   input  logic [31:0] addr_i,
   input  logic        we_i,
   output logic        valid_o,
   output logic        err_o
);

   dec_t dec;

   assign dec     = addr_decode(addr_i, we_i);
   assign valid_o = dec.valid;
   assign err_o   = dec.err;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with bounded burst lock.
// Master 0 is the CPU data port, master 1 the UART loader / DMA.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   m{0,1}_req_i/lock_i            transfer request, keep-grant request
//   m{0,1}_addr_i/we_i/wdata_i     transfer attributes (stable while req)
//   m{0,1}_gnt_o                   grant, transfer completes in this cycle
//   m{0,1}_rvalid_o/rdata_o/err_o  registered response, one cycle later
//   bus_valid_o/we_o/addr_o/wdata_o  slave side, from the granted master
//   bus_rdata_i                    read data from the processor read mux
//   state_o                        current FSM state, for observation
//
// Handshake: a master raises req with addr/we/wdata and holds them until it
// sees gnt. The transfer completes at the clock edge that ends the gnt cycle;
// req still high at that edge asks for another transfer. rvalid pulses for
// exactly one cycle after each gnt cycle and qualifies rdata and err.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        m0_req_i,
   input  logic        m1_req_i,
   input  logic        m0_lock_i,
   input  logic        m1_lock_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m1_addr_i,
   input  logic        m0_we_i,
   input  logic        m1_we_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m0_gnt_o,
   output logic        m1_gnt_o,
   output logic        m0_rvalid_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic [31:0] m1_rdata_o,
   output logic        m0_err_o,
   output logic        m1_err_o,
   output logic        bus_valid_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   output state_t      state_o
);

   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0] BEAT_LIM = BW'(MAX_BURST - 1);
   localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);

   state_t        state, state_nxt;
   logic          last, last_nxt;
   logic [BW-1:0] beat, beat_nxt;
   logic          cur_req, cur_lock, oth_req;
   logic          dec_valid, dec_err;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         last  <= 1'b1;
         beat  <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         beat  <= beat_nxt;
      end
   end

   // Next state
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      beat_nxt  = beat;
      cur_req   = 1'b0;
      cur_lock  = 1'b0;
      oth_req   = 1'b0;
      case (state)
         IDLE: begin
            beat_nxt = '0;
            if (m0_req_i && m1_req_i) state_nxt = last ? GNT0 : GNT1;
            else if (m0_req_i)        state_nxt = GNT0;
            else if (m1_req_i)        state_nxt = GNT1;
         end
         GNT0, GNT1: begin
            cur_req  = (state == GNT0) ? m0_req_i  : m1_req_i;
            cur_lock = (state == GNT0) ? m0_lock_i : m1_lock_i;
            oth_req  = (state == GNT0) ? m1_req_i  : m0_req_i;
            last_nxt = (state == GNT1);
            if (cur_req && cur_lock && (!oth_req || (beat < BEAT_LIM))) begin
               // Saturate so a long uncontended lock cannot wrap the count
               // and re-open the burst window once the other master asks.
               beat_nxt = (beat == BEAT_MAX) ? beat : beat + BW'(1);
            end else if (oth_req) begin
               state_nxt = (state == GNT0) ? GNT1 : GNT0;
               beat_nxt  = '0;
            end else if (cur_req) begin
               beat_nxt  = '0;
            end else begin
               state_nxt = IDLE;
               beat_nxt  = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            beat_nxt  = '0;
         end
      endcase
   end

   assign m0_gnt_o = (state == GNT0);
   assign m1_gnt_o = (state == GNT1);
   assign state_o  = state;

   // Only the granted master's attributes reach the slaves.
   always_comb begin
      bus_addr_o  = '0;
      bus_we_o    = 1'b0;
      bus_wdata_o = '0;
      if (state == GNT0) begin
         bus_addr_o  = m0_addr_i;
         bus_we_o    = m0_we_i;
         bus_wdata_o = m0_wdata_i;
      end else if (state == GNT1) begin
         bus_addr_o  = m1_addr_i;
         bus_we_o    = m1_we_i;
         bus_wdata_o = m1_wdata_i;
      end
   end

   bus_addr_decode u_dec (
      .addr_i  (bus_addr_o),
      .we_i    (bus_we_o),
      .valid_o (dec_valid),
      .err_o   (dec_err)
   );

   assign bus_valid_o = (m0_gnt_o || m1_gnt_o) && dec_valid;

   // Response registers; rdata and err hold between responses.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         m0_rvalid_o <= 1'b0;
         m1_rvalid_o <= 1'b0;
         m0_rdata_o  <= '0;
         m1_rdata_o  <= '0;
         m0_err_o    <= 1'b0;
         m1_err_o    <= 1'b0;
      end else begin
         m0_rvalid_o <= m0_gnt_o;
         m1_rvalid_o <= m1_gnt_o;
         if (m0_gnt_o) begin
            m0_rdata_o <= (bus_we_o || dec_err) ? '0 : bus_rdata_i;
            m0_err_o   <= dec_err;
         end
         if (m1_gnt_o) begin
            m1_rdata_o <= (bus_we_o || dec_err) ? '0 : bus_rdata_i;
            m1_err_o   <= dec_err;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of the key scenarios followed by a
// randomized two-master run scored against a behavioural model.
module tb_bus_arbiter;
   import bus_pkg::*;

   localparam int MAX_BURST = 4;
   localparam logic [31:0] IO_TAB [12] = '{
      32'h2000, 32'h2004, 32'h2008, 32'h2010, 32'h2018, 32'h201C,
      32'h2020, 32'h2028, 32'h202C, 32'h2030, 32'h2038, 32'h203C};

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, lock, we;
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [31:0] bus_rdata;
   logic        gnt0, gnt1, rv0, rv1, er0, er1, bus_valid, bus_we;
   logic [31:0] rd0, rd1, bus_addr, bus_wdata;
   state_t      dbg_state;

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_req_i(req[0]), .m1_req_i(req[1]),
      .m0_lock_i(lock[0]), .m1_lock_i(lock[1]),
      .m0_addr_i(addr[0]), .m1_addr_i(addr[1]),
      .m0_we_i(we[0]), .m1_we_i(we[1]),
      .m0_wdata_i(wdata[0]), .m1_wdata_i(wdata[1]),
      .m0_gnt_o(gnt0), .m1_gnt_o(gnt1),
      .m0_rvalid_o(rv0), .m1_rvalid_o(rv1),
      .m0_rdata_o(rd0), .m1_rdata_o(rd1),
      .m0_err_o(er0), .m1_err_o(er1),
      .bus_valid_o(bus_valid), .bus_we_o(bus_we),
      .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .bus_rdata_i(bus_rdata),
      .state_o(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   logic [32:0] hold [2];
   logic [1:0]  due;
   int          m_cur, old_cur, m_beat;
   logic        m_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a, input logic w);
      logic hit;
      hit = (a >= 32'h1000) && (a <= 32'h13F8);
      for (int i = 0; i < 12; i++) if (a == IO_TAB[i]) hit = 1'b1;
      return !hit || (a[1:0] != 2'b00) || (w && (a == 32'h2000));
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = '0; lock = '0; we = '0; bus_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; wdata[i] = '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      exp_q0.delete(); exp_q1.delete();
      hold[0] = '0; hold[1] = '0; due = '0;
      m_cur = -1; old_cur = -1; m_beat = 0; m_last = 1'b1;
   endtask

   task automatic check_all_zero(input string t);
      check({t, "_ctl"}, {gnt0, gnt1, rv0, rv1, er0, er1, bus_valid, bus_we}, 8'h00);
      check({t, "_rd0"}, rd0, 32'h0);
      check({t, "_rd1"}, rd1, 32'h0);
      check({t, "_baddr"}, bus_addr, 32'h0);
      check({t, "_bwdata"}, bus_wdata, 32'h0);
      check({t, "_state"}, dbg_state, IDLE);
   endtask

   // Single master-0 transfer from idle: grant cycle, response cycle, idle.
   task automatic m0_xfer(input string t, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [31:0] rdin,
                          input logic exp_er, input logic [31:0] exp_rd);
      req[0] = 1'b1; addr[0] = a; we[0] = w; wdata[0] = d; bus_rdata = rdin;
      tick();
      check({t, "_gnt"}, gnt0, 1'b1);
      check({t, "_bvalid"}, bus_valid, !exp_er);
      check({t, "_baddr"}, bus_addr, a);
      check({t, "_bwe"}, bus_we, w);
      if (w) check({t, "_bwdata"}, bus_wdata, d);
      req[0] = 1'b0;
      tick();
      check({t, "_rvalid"}, rv0, 1'b1);
      check({t, "_err"}, er0, exp_er);
      check({t, "_rdata"}, rd0, exp_rd);
      check({t, "_gnt_off"}, gnt0, 1'b0);
      tick();
      check({t, "_rvalid_off"}, rv0, 1'b0);
      check({t, "_rdata_hold"}, rd0, exp_rd);
   endtask

   task automatic new_fields(input int x);
      case ($urandom_range(0, 5))
         0, 1: addr[x] = 32'h1000 + 4 * $urandom_range(0, 254);
         2:    addr[x] = IO_TAB[$urandom_range(0, 11)];
         3:    addr[x] = 32'h1000 + 4 * $urandom_range(0, 254) + $urandom_range(1, 3);
         4: case ($urandom_range(0, 3))
               0: addr[x] = 32'h13FC;
               1: addr[x] = 32'h0FFC;
               2: addr[x] = 32'h2000;
               default: addr[x] = 32'h2014;
            endcase
         default: addr[x] = $urandom;
      endcase
      we[x]    = 1'($urandom_range(0, 1));
      wdata[x] = $urandom;
   endtask

   // ---------------- reference model ----------------
   // Called at each rising edge with the inputs that edge samples.
   task automatic model_step();
      int   x, o;
      logic e;
      logic [31:0] r;
      old_cur = m_cur;
      due = '0;
      if (m_cur >= 0) begin
         x = m_cur;
         o = 1 - x;
         e = model_err(addr[x], we[x]);
         r = (e || we[x]) ? 32'h0 : bus_rdata;
         if (x == 0) exp_q0.push_back({e, r}); else exp_q1.push_back({e, r});
         due[x] = 1'b1;
         m_last = (x == 1);
         if (req[x] && lock[x] && (!req[o] || m_beat < MAX_BURST - 1)) begin
            m_beat++;
         end else if (req[o]) begin
            m_cur = o; m_beat = 0;
         end else if (req[x]) begin
            m_beat = 0;
         end else begin
            m_cur = -1; m_beat = 0;
         end
      end else begin
         if (req == 2'b11) m_cur = m_last ? 0 : 1;
         else if (req[0]) m_cur = 0;
         else if (req[1]) m_cur = 1;
      end
   endtask

   task automatic drive_random();
      for (int x = 0; x < 2; x++) begin
         if (old_cur == x) begin
            if (req[x]) new_fields(x);
         end
         if (m_cur == x) begin
            req[x] = ($urandom_range(0, 99) < 60);
         end else if (!req[x] && ($urandom_range(0, 99) < 40)) begin
            req[x] = 1'b1;
            new_fields(x);
         end
         lock[x] = ($urandom_range(0, 99) < 55);
      end
      bus_rdata = $urandom;
   endtask

   task automatic cmp_resp(input int x, input logic rv, input logic [31:0] rd, input logic er);
      string t;
      t = (x == 0) ? "m0" : "m1";
      check({t, "_rvalid"}, rv, due[x]);
      if (due[x]) begin
         if (x == 0 && exp_q0.size() > 0) hold[0] = exp_q0.pop_front();
         if (x == 1 && exp_q1.size() > 0) hold[1] = exp_q1.pop_front();
         check({t, "_err"}, er, hold[x][32]);
      end
      check({t, "_rdata"}, rd, hold[x][31:0]);
   endtask

   task automatic compare_cycle();
      int x;
      check("gnt0", gnt0, m_cur == 0);
      check("gnt1", gnt1, m_cur == 1);
      if (m_cur >= 0) begin
         x = m_cur;
         check("bus_valid", bus_valid, !model_err(addr[x], we[x]));
         check("bus_addr", bus_addr, addr[x]);
         check("bus_we", bus_we, we[x]);
         check("bus_wdata", bus_wdata, wdata[x]);
      end else begin
         check("bus_idle", {bus_valid, bus_we}, 2'b00);
         check("bus_addr_idle", bus_addr, 32'h0);
      end
      cmp_resp(0, rv0, rd0, er0);
      cmp_resp(1, rv1, rd1, er1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      do_reset();
      check_all_zero("reset");

      // Basic read latency and data return.
      m0_xfer("rd1004", 32'h1004, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);

      // Reset landing on a grant cycle: no response afterwards.
      req[0] = 1'b1; addr[0] = 32'h1008; we[0] = 1'b0; bus_rdata = 32'h1234_5678;
      tick();
      check("rstgnt_gnt", gnt0, 1'b1);
      rst_n = 1'b0;
      tick();
      check_all_zero("rstgnt");
      req[0] = 1'b0;
      tick();
      check("rstgnt_no_rvalid", rv0, 1'b0);

      do_reset();
      m0_xfer("wr_sw", 32'h2000, 1'b1, 32'h55, 32'hA5A5_A5A5, 1'b1, 32'h0);
      m0_xfer("rd_13fc", 32'h13FC, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1, 32'h0);
      m0_xfer("rd_1002", 32'h1002, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1, 32'h0);
      m0_xfer("rd_13f8", 32'h13F8, 1'b0, 32'h0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE);
      m0_xfer("wr_led", 32'h2004, 1'b1, 32'h5A, 32'hFFFF_FFFF, 1'b0, 32'h0);

      // Both requesting, no lock: strict alternation starting with m0.
      do_reset();
      req = 2'b11;
      addr[0] = 32'h1010; addr[1] = 32'h1020;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("alt_gnt0", gnt0, (i % 2) == 0);
         check("alt_gnt1", gnt1, (i % 2) == 1);
      end

      // m1 locked while m0 waits: MAX_BURST grants, then m0.
      do_reset();
      req[1] = 1'b1; lock[1] = 1'b1; addr[1] = 32'h1100;
      tick();
      check("burst_g1_first", gnt1, 1'b1);
      req[0] = 1'b1; addr[0] = 32'h1200;
      for (int i = 1; i < MAX_BURST; i++) begin
         tick();
         check("burst_g1", gnt1, 1'b1);
         check("burst_g0_wait", gnt0, 1'b0);
      end
      tick();
      check("burst_switch_g0", gnt0, 1'b1);
      check("burst_switch_g1", gnt1, 1'b0);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         model_step();
         #1;
         drive_random();
         @(negedge clk);
         compare_cycle();
      end
      check("q0_drained", exp_q0.size(), 0);
      check("q1_drained", exp_q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
